mem_bus_if: RTL and testbench

MEM_BUS_IF -- requirements
Module: mem_bus_if

---
 rtl/mem_bus_if_pkg.sv | 16 +
 rtl/cs_decode.sv | 32 +++
 rtl/mem_bus_if.sv | 142 ++++++++++++++
 tb/tb_mem_bus_if.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_if_pkg.sv
// mem_bus_if_pkg: shared FSM state encoding and bus-direction constants
// for the pipeline-to-memory bus interface.
`default_nettype none

package mem_bus_if_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

endpackage

`default_nettype wire

// File: rtl/cs_decode.sv
// cs_decode: combinational region decoder, maps addr[ADDR_W-1:REG_SHIFT]
// to a one-hot chip select and flags whether the region is mapped.
`default_nettype none

module cs_decode #(
    parameter int ADDR_W    = 32,
    parameter int N_CS      = 4,
    parameter int REG_SHIFT = 28
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [N_CS-1:0]   cs_o,
    output logic              hit_o
);

    localparam int c_rw = ADDR_W - REG_SHIFT;
    // Wide enough to hold N_CS itself, so the range compare never truncates.
    localparam int c_cw = (c_rw > 5) ? c_rw : 5;

    logic [c_cw-1:0] w_region;
    logic            w_unused_low;

    assign w_region     = c_cw'(addr_i[ADDR_W-1:REG_SHIFT]);
    assign w_unused_low = ^addr_i[REG_SHIFT-1:0];
    assign hit_o        = (w_region < c_cw'(N_CS));

    for (genvar i = 0; i < N_CS; i++) begin : g_cs
        assign cs_o[i] = hit_o && (w_region == c_cw'(i));
    end

endmodule

`default_nettype wire

// File: rtl/mem_bus_if.sv
// mem_bus_if: IDLE/ACCESS/DONE bus master between a stalling pipeline and
// chip-selected memory regions. Define MEM_BUS_TIMEOUT_EN to abort long waits.
`default_nettype none

module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int N_CS      = 4,
    parameter int REG_SHIFT = 28,
    parameter int TIMEOUT   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [N_CS-1:0]   cs,
    output logic              wr_rd,
    output logic [DATA_W-1:0] data_bus_write,
    input  logic [DATA_W-1:0] data_bus_read,
    input  logic              ready
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [N_CS-1:0]   cs_q;
    logic              wr_rd_q;
    logic              err_q;

    logic [N_CS-1:0]   w_cs_dec;
    logic              w_hit;
    logic              w_timeout;

    cs_decode #(
        .ADDR_W    (ADDR_W),
        .N_CS      (N_CS),
        .REG_SHIFT (REG_SHIFT)
    ) u_cs_decode (
        .addr_i (req_addr),
        .cs_o   (w_cs_dec),
        .hit_o  (w_hit)
    );

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    logic [c_cnt_w-1:0] wait_q;

    assign w_timeout = ~ready && (wait_q == c_cnt_w'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (state_q == ST_ACCESS && !ready && !w_timeout) begin
            wait_q <= wait_q + 1'b1;
        end else begin
            wait_q <= '0;
        end
    end
`else
    localparam int c_unused_timeout = TIMEOUT;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req) state_d = w_hit ? ST_ACCESS : ST_DONE;
            ST_ACCESS: if (ready || w_timeout) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack   = (state_q == ST_DONE);
        err   = ack & err_q;
        stall = req & ~ack;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cs_q    <= '0;
            wr_rd_q <= RD;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wr_rd_q <= we;
                        cs_q    <= w_cs_dec;
                        err_q   <= ~w_hit;
                        if (!w_hit) rdata_q <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (ready) begin
                        cs_q  <= '0;
                        err_q <= 1'b0;
                        if (wr_rd_q != WR) rdata_q <= data_bus_read;
                    end else if (w_timeout) begin
                        cs_q    <= '0;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign addr           = addr_q;
    assign cs             = cs_q;
    assign wr_rd          = wr_rd_q;
    assign data_bus_write = wdata_q;
    assign rdata          = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: directed and randomized checks of mem_bus_if against a
// transaction-level model (expected latency, chip select and read data).
`default_nettype none

module tb_mem_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, ready;
    logic [31:0] req_addr, req_wdata, data_bus_read;
    logic        stall, ack, err, wr_rd;
    logic [31:0] rdata, addr, data_bus_write;
    logic [3:0]  cs;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdata = '0;

    mem_bus_if #(
        .DATA_W(32), .ADDR_W(32), .N_CS(4), .REG_SHIFT(28), .TIMEOUT(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .we             (we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .ack            (ack),
        .err            (err),
        .rdata          (rdata),
        .addr           (addr),
        .cs             (cs),
        .wr_rd          (wr_rd),
        .data_bus_write (data_bus_write),
        .data_bus_read  (data_bus_read),
        .ready          (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns one idle cycle after ack.
    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [31:0] bus, input int wait_n);
        logic        mapped;
        logic [31:0] exp_cs;
        mapped = (a[31:28] < 4'd4);
        exp_cs = mapped ? (32'd1 << a[31:28]) : 32'd0;
        req = 1'b1; we = w; req_addr = a; req_wdata = wd;
        data_bus_read = bus; ready = 1'b0;
        #1 chk("stall_c0", 32'(stall), 32'd1);
        if (mapped) begin
            for (int c = 1; c <= wait_n + 1; c++) begin
                @(negedge clk);
                chk("cs_access", 32'(cs), exp_cs);
                chk("stall_access", 32'(stall), 32'd1);
                chk("ack_early", 32'(ack), 32'd0);
                if (c == 1) begin
                    chk("addr", addr, a);
                    chk("wr_rd", 32'(wr_rd), 32'(w));
                    chk("data_bus_write", data_bus_write, wd);
                end
                ready = (c == wait_n + 1);
            end
            @(negedge clk);
            chk("ack_done", 32'(ack), 32'd1);
            chk("err_done", 32'(err), 32'd0);
            chk("cs_done", 32'(cs), 32'd0);
            chk("stall_done", 32'(stall), 32'd0);
            if (!w) exp_rdata = bus;
        end else begin
            @(negedge clk);
            chk("ack_unmapped", 32'(ack), 32'd1);
            chk("err_unmapped", 32'(err), 32'd1);
            chk("cs_unmapped", 32'(cs), 32'd0);
            exp_rdata = 32'd0;
        end
        chk("rdata", rdata, exp_rdata);
        req = 1'b0; ready = 1'b0;
        @(negedge clk);
        chk("ack_after", 32'(ack), 32'd0);
        chk("cs_after", 32'(cs), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; ready = 1'b0;
        req_addr = '0; req_wdata = '0; data_bus_read = '0;
        #3;
        chk("rst_cs", 32'(cs), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_wr_rd", 32'(wr_rd), 32'd0);
        chk("rst_dbw", data_bus_write, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Directed: minimum-latency read, delayed write, unmapped read
        txn(32'h1000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF, 0);
        txn(32'h3000_0004, 1'b1, 32'h55, 32'h1234_5678, 3);
        txn(32'h7000_0000, 1'b0, 32'h0, 32'hCAFE_F00D, 0);

        // Slave never answers
        req = 1'b1; we = 1'b0; req_addr = 32'h0; ready = 1'b0; data_bus_read = 32'hA5A5_0001;
`ifdef MEM_BUS_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("to_cs", 32'(cs), 32'd1);
            chk("to_ack_early", 32'(ack), 32'd0);
        end
        @(negedge clk);
        chk("to_ack", 32'(ack), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_rdata", rdata, 32'd0);
        chk("to_cs_clear", 32'(cs), 32'd0);
        exp_rdata = 32'd0;
`else
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk("wait_stall", 32'(stall), 32'd1);
            chk("wait_ack", 32'(ack), 32'd0);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("wait_ack_done", 32'(ack), 32'd1);
        chk("wait_err", 32'(err), 32'd0);
        chk("wait_rdata", rdata, 32'hA5A5_0001);
        exp_rdata = 32'hA5A5_0001;
`endif
        req = 1'b0; ready = 1'b0;
        @(negedge clk);

        // Reset in the second cycle of a waiting access
        req = 1'b1; we = 1'b0; req_addr = 32'h1000_0020; ready = 1'b0;
        @(negedge clk);
        chk("rstmid_cs_before", 32'(cs), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_cs", 32'(cs), 32'd0);
        chk("rstmid_ack", 32'(ack), 32'd0);
        chk("rstmid_addr", addr, 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        #1 rst = 1'b0; req = 1'b0;
        exp_rdata = 32'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstmid_no_ack", 32'(ack), 32'd0);
        end
        txn(32'h1000_0040, 1'b0, 32'h0, 32'h0BAD_F00D, 1);

        // Back-to-back reads, req held across ack
        req = 1'b1; we = 1'b0; req_addr = 32'h0000_0100; ready = 1'b1; data_bus_read = 32'h1111_0000;
        @(negedge clk);
        chk("b2b_cs0", 32'(cs), 32'd1);
        @(negedge clk);
        chk("b2b_ack0", 32'(ack), 32'd1);
        chk("b2b_rdata0", rdata, 32'h1111_0000);
        chk("b2b_cs_gap", 32'(cs), 32'd0);
        req_addr = 32'h2000_0200; data_bus_read = 32'h2222_0000;
        @(negedge clk);
        chk("b2b_idle_ack", 32'(ack), 32'd0);
        chk("b2b_idle_cs", 32'(cs), 32'd0);
        chk("b2b_idle_stall", 32'(stall), 32'd1);
        @(negedge clk);
        chk("b2b_cs2", 32'(cs), 32'd4);
        @(negedge clk);
        chk("b2b_ack2", 32'(ack), 32'd1);
        chk("b2b_rdata2", rdata, 32'h2222_0000);
        exp_rdata = 32'h2222_0000;
        req = 1'b0; ready = 1'b0;
        @(negedge clk);

        // Randomized transactions against the model
        for (int k = 0; k < 12; k++) begin
            logic [3:0]  reg_n;
            logic [31:0] a;
            reg_n = 4'($urandom_range(0, 7));
            a     = {reg_n, 28'($urandom)};
            txn(a, 1'($urandom), $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
